// File: rtl/fpu_pipe_stage.sv
// ============================================================================
// Module   : fpu_pipe_stage
// Brief    : Valid/ready FPU pipeline stage with optional two-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_pipe_stage #(
    parameter int DW   = 126,
    parameter int SKID = 1,
    parameter int CW   = 16
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          e,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam logic [CW-1:0] STALL_ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic [CW-1:0] stall_q, stall_d;

    logic w_active;
    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    assign w_active    = e && !flush;
    assign w_out_valid = w_active && (state_q != ST_EMPTY);

    // With the skid entry, ready depends on registered state only, cutting the
    // combinational out_ready -> in_ready path between stages.
    generate
        if (SKID != 0) begin : g_skid_ready
            assign w_in_ready = w_active && (state_q != ST_SKID);
        end else begin : g_pass_ready
            assign w_in_ready = w_active && ((state_q == ST_EMPTY) || out_ready);
        end
    endgenerate

    assign w_push = in_valid && w_in_ready;
    assign w_pop  = w_out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        stall_d = stall_q;

        if (w_active) begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_push) begin
                        state_d = ST_FULL;
                        main_d  = in_data;
                    end
                end
                ST_FULL: begin
                    if (w_push && w_pop) begin
                        main_d = in_data;
                    end else if (w_push && (SKID != 0)) begin
                        state_d = ST_SKID;
                        skid_d  = in_data;
                    end else if (w_pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (w_pop) begin
                        state_d = ST_FULL;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end else if (e && flush) begin
            // Payload registers keep their contents; only validity is dropped.
            state_d = ST_EMPTY;
        end

        if (w_out_valid && !out_ready && (stall_q != {CW{1'b1}})) begin
            stall_d = stall_q + STALL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = main_q;
    assign stall_cnt = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_pipe_stage.sv
// ============================================================================
// Module   : tb_fpu_pipe_stage
// Brief    : Scoreboard bench for fpu_pipe_stage, skid (CW=16) and pass-through (CW=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_pipe_stage;

    localparam int DW = 126;

    logic          clk;
    logic          clr;
    logic          e;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          ir_a, ov_a, ir_b, ov_b;
    logic [DW-1:0] od_a, od_b;
    logic [15:0]   sc_a;
    logic [2:0]    sc_b;

    fpu_pipe_stage #(.DW(DW), .SKID(1), .CW(16)) u_dut_skid (
        .clk(clk), .clr(clr), .e(e), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_a), .in_data(in_data),
        .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
        .stall_cnt(sc_a)
    );

    fpu_pipe_stage #(.DW(DW), .SKID(0), .CW(3)) u_dut_pass (
        .clk(clk), .clr(clr), .e(e), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_b), .in_data(in_data),
        .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b),
        .stall_cnt(sc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    // Index 0: skid variant (capacity 2, CW=16); index 1: pass-through (capacity 1, CW=3).
    logic [DW-1:0] mq [2][$];
    int            ms [2];
    bit            zero_exp [2];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    logic          exp_ir, exp_ov;
    logic          act_ir, act_ov;
    logic [DW-1:0] act_od;
    logic [15:0]   act_sc;
    int            cap, sat;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                cap    = (d == 0) ? 2 : 1;
                sat    = (d == 0) ? 65535 : 7;
                act_ir = (d == 0) ? ir_a : ir_b;
                act_ov = (d == 0) ? ov_a : ov_b;
                act_od = (d == 0) ? od_a : od_b;
                act_sc = (d == 0) ? sc_a : {13'd0, sc_b};

                exp_ir = e && !flush && ((mq[d].size() < cap) || (d == 1 && out_ready));
                exp_ov = e && !flush && (mq[d].size() > 0);

                check($sformatf("in_ready[%0d]", d), {127'd0, act_ir}, {127'd0, exp_ir});
                check($sformatf("out_valid[%0d]", d), {127'd0, act_ov}, {127'd0, exp_ov});
                if (exp_ov)
                    check($sformatf("out_data[%0d]", d), {2'b0, act_od}, {2'b0, mq[d][0]});
                else if (zero_exp[d])
                    check($sformatf("out_data_rst[%0d]", d), {2'b0, act_od}, 128'd0);
                check($sformatf("stall_cnt[%0d]", d), {112'd0, act_sc}, 128'(ms[d]));

                if (clr) begin
                    mq[d].delete();
                    ms[d]       = 0;
                    zero_exp[d] = 1'b1;
                end else if (e) begin
                    if (flush) begin
                        mq[d].delete();
                    end else begin
                        if (exp_ov && out_ready) void'(mq[d].pop_front());
                        if (exp_ir && in_valid) begin
                            mq[d].push_back(in_data);
                            zero_exp[d] = 1'b0;
                        end
                        if (exp_ov && !out_ready && ms[d] < sat) ms[d]++;
                    end
                end
            end
        end
    end

    task automatic drive(input int n, input logic iv, input logic [DW-1:0] d,
                         input logic ordy, input logic en, input logic fl, input logic cl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        e         = en;
        flush     = fl;
        clr       = cl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            ms[d]       = 0;
            zero_exp[d] = 1'b1;
        end
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        e = 1'b1; flush = 1'b0; clr = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        drive(1, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);

        // Sustained stream 1..8 with downstream always ready.
        for (int i = 1; i <= 8; i++) drive(1, 1'b1, DW'(i), 1'b1, 1'b1, 1'b0, 1'b0);
        drive(3, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Fill skid with 0xA/0xB while blocked, stall long enough to saturate CW=3.
        drive(1, 1'b1, DW'('hA), 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1, 1'b1, DW'('hB), 1'b0, 1'b1, 1'b0, 1'b0);
        drive(5, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(10, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(4, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Flush a full skid while 0xC is offered.
        drive(1, 1'b1, DW'('h11), 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1, 1'b1, DW'('h12), 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1, 1'b1, DW'('hC), 1'b0, 1'b1, 1'b1, 1'b0);
        drive(3, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Freeze with 0xD held, then release.
        drive(1, 1'b1, DW'('hD), 1'b0, 1'b1, 1'b0, 1'b0);
        drive(3, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(3, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Clear while holding entries.
        drive(2, 1'b1, DW'('h21), 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(3, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);

        repeat (3000) begin
            drive(1, ($urandom_range(0, 9) < 7), rnd_data(),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 95),
                  ($urandom_range(0, 99) < 3), ($urandom_range(0, 199) == 0));
        end

        drive(6, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fpu_pipe_stage.md
FPU_PIPE_STAGE -- requirements
Module: fpu_pipe_stage

Interface
REQ-001 Parameter DW, default 126, payload width in bits (packed stage fields: sum, carry, frac, exp, z8, rm, sign, nan, inf).
REQ-002 Parameter SKID, default 1, 1 = two-entry skid buffer (main + skid), 0 = single register with pass-through ready.
REQ-003 Parameter CW, default 16, stall counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 clr  input  1  reset, synchronous, active-high.
REQ-006 e  input  1  stage enable; 0 freezes all state.
REQ-007 flush  input  1  discard all held entries.
REQ-008 in_valid  input  1  upstream payload valid.
REQ-009 in_ready  output  1  stage accepts payload this cycle.
REQ-010 in_data  input  DW  upstream payload.
REQ-011 out_valid  output  1  main entry valid to downstream.
REQ-012 out_ready  input  1  downstream accepts.
REQ-013 out_data  output  DW  main entry payload, driven directly from a register.
REQ-014 stall_cnt  output  CW  cycles with out_valid=1 and out_ready=0.

Function
REQ-015 push = in_valid && in_ready; pop = out_valid && out_ready; no other event moves data.
REQ-016 States: EMPTY (no entry), FULL (main valid), SKID (main+skid valid); SKID unreachable when SKID=0.
REQ-017 out_valid = e && !flush && state != EMPTY.
REQ-018 SKID=1: in_ready = e && !flush && state != SKID (registered-state only, no path from out_ready).
REQ-019 SKID=0: in_ready = e && !flush && (state == EMPTY || out_ready).
REQ-020 EMPTY: push -> FULL, main <= in_data.
REQ-021 FULL: push && pop -> FULL, main <= in_data; push && !pop -> SKID, skid <= in_data (SKID=1 only); pop && !push -> EMPTY; neither -> hold.
REQ-022 SKID: pop -> FULL, main <= skid; no push possible.
REQ-023 Latency: payload accepted at edge N appears on out_data/out_valid after edge N; no combinational in_data -> out_data path.
REQ-024 Order preserved: entries leave in acceptance order; no entry duplicated or dropped except by flush/clr.
REQ-025 e=0: state, main, skid, stall_cnt hold; in_ready=0, out_valid=0.
REQ-026 flush=1 with e=1: next state EMPTY; main/skid data retained but invalid; simultaneous in_valid is not accepted.
REQ-027 flush with e=0: ignored.
REQ-028 stall_cnt increments by 1 each cycle e && !flush && state != EMPTY && !out_ready; saturates at 2^CW-1; unaffected by flush.
REQ-029 Throughput: one transfer per cycle sustained when out_ready=1 continuously, both SKID settings.

Reset
REQ-030 clr=1 at an edge: state EMPTY, main=0, skid=0, stall_cnt=0; overrides e, flush, push, pop.
REQ-031 During clr cycle outputs follow current state; after the edge out_valid=0, out_data=0, in_ready=e.
REQ-032 clr mid-operation (FULL or SKID) drops all held entries; no entry emerges afterwards.

Verification
REQ-033 clr, then in_valid=1 in_data=0x1 with out_ready=1, e=1 -> next cycle out_valid=1, out_data=0x1; continuous stream 0x1..0x8 emerges 0x1..0x8 one per cycle.
REQ-034 SKID=1, out_ready=0, push 0xA then 0xB -> state SKID, in_ready=0, out_data=0xA; raise out_ready -> 0xA then 0xB, then out_valid=0.
REQ-035 FULL, out_ready=0 for 5 cycles -> stall_cnt=5; CW=3 held 10 cycles -> stall_cnt=7.
REQ-036 SKID state, flush=1 with in_valid=1 in_data=0xC -> next cycle out_valid=0, in_ready=1, 0xC never appears.
REQ-037 FULL with 0xD, e=0 for 3 cycles with out_ready=1 -> out_valid=0, no pop, stall_cnt unchanged; e=1 -> 0xD delivered once.
REQ-038 SKID=0, FULL, out_ready=1, in_valid=1 -> in_ready=1 same cycle, back-to-back transfer; out_ready=0 -> in_ready=0.
